// File: rtl/fb_readback.sv
// Frame-buffer readback: reads up to 32 consecutive pixels from the RAM read
// port and packs them LSB-first into one 32-bit custom-instruction result.
module fb_readback #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned WORDS       = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic              q,
  output logic              busy,
  output logic [31:0]       result,
  output logic              done
);

  localparam int unsigned PIX_W = 5;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned IDX_W = ADDR_W - PIX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FINISH
  } state_t;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_addr;
  logic [CNT_W-1:0]       r_n;
  logic [CNT_W-1:0]       r_iss;
  logic [CNT_W-1:0]       r_smp;
  logic                   r_addr_vld;
  logic [RAM_LATENCY-1:0] r_pipe;
  logic                   r_busy;
  logic                   r_done;
  logic [31:0]            r_result;

  logic [CNT_W-1:0]       w_nraw;
  logic [CNT_W-1:0]       w_n;
  logic                   w_idx_ok;
  logic [ADDR_W-1:0]      w_base;
  logic                   w_smp;
  logic                   w_last;
  logic                   w_unused_bits;

  // Pixel count: 0 or anything above 32 means a full word.
  assign w_nraw   = datab[CNT_W-1:0];
  assign w_n      = ((w_nraw == '0) || (w_nraw > CNT_W'(32))) ? CNT_W'(32) : w_nraw;
  assign w_idx_ok = (dataa < 32'(WORDS));
  assign w_base   = {dataa[IDX_W-1:0], PIX_W'(0)};
  assign w_smp    = r_pipe[RAM_LATENCY-1];
  assign w_last   = w_smp && (r_smp == (r_n - CNT_W'(1)));

  assign w_unused_bits = &{1'b0, datab[31:CNT_W]};

  // Valid pipeline: a set bit at the tail means q now carries an issued address.
  generate
    if (RAM_LATENCY == 1) begin : g_pipe_1
      always_ff @(posedge clk) begin
        if (reset || (r_state != S_READ)) r_pipe <= '0;
        else                              r_pipe <= r_addr_vld;
      end
    end else begin : g_pipe_n
      always_ff @(posedge clk) begin
        if (reset || (r_state != S_READ)) r_pipe <= '0;
        else                              r_pipe <= {r_pipe[RAM_LATENCY-2:0], r_addr_vld};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_n        <= '0;
      r_iss      <= '0;
      r_smp      <= '0;
      r_addr_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_result <= '0;
            if (w_idx_ok) begin
              r_addr     <= w_base;
              r_n        <= w_n;
              r_iss      <= CNT_W'(1);
              r_smp      <= '0;
              r_addr_vld <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_READ;
            end else begin
              // Out-of-range word: answer zero without touching the RAM.
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end
        S_READ: begin
          if (r_iss < r_n) begin
            r_addr     <= r_addr + ADDR_W'(1);
            r_iss      <= r_iss + CNT_W'(1);
            r_addr_vld <= 1'b1;
          end else begin
            r_addr_vld <= 1'b0;
          end
          if (w_smp) begin
            r_result[r_smp[PIX_W-1:0]] <= q;
            r_smp                      <= r_smp + CNT_W'(1);
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdaddress = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule
